// File: rtl/ssd_pkg.sv
// Shared constants and BCD decode for the seven-segment scan path.
// All segment patterns are active-low: [7:1] = a..g, [0] = dp.
package ssd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [3:0] CTL_OFF   = 4'hF;

  localparam logic [6:0] SEG7_DASH = 7'b1111110;
  localparam logic [6:0] SEG7_OFF  = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] bcd
  );
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG7_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_digit_dec.sv
// One digit's segment pattern: BCD + decimal point, with optional
// suppression of a..g (the dp stays visible when suppressed).
module ssd_digit_dec
  import ssd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] segs
);

  assign segs = {blank ? SEG7_OFF : bcd_to_seg(bcd), ~dp};

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit SSD scan scheduler: per-frame snapshot, blanking guard,
// leading-zero suppression and registered pin outputs.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int BLANK_CYC = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [7:0]  segs,
  output logic [3:0]  ssd_ctl,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic [3:0]    snap_dp;

  logic          wrap;
  logic          load;
  logic [15:0]   cur_snap;
  logic [3:0]    cur_dp;
  logic [3:0]    digit;
  logic [3:0]    lz_mask;
  logic          blank_phase;
  logic [7:0]    dec_segs;
  logic [7:0]    segs_next;
  logic [3:0]    ctl_next;

  assign wrap = (cnt == CNT_LAST);
  assign load = en && (idx == 2'd0) && (cnt == '0);

  // Slot 0 decodes from the value being captured this cycle.
  assign cur_snap = load ? digits_in : snap;
  assign cur_dp   = load ? dp_in : snap_dp;
  assign digit    = cur_snap[{idx, 2'b00} +: 4];

  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (cur_snap[15:12] == 4'd0);
    lz_mask[2] = lz_mask[3] && (cur_snap[11:8] == 4'd0);
    lz_mask[1] = lz_mask[2] && (cur_snap[7:4] == 4'd0);
  end

  ssd_digit_dec u_dec (
    .bcd   (digit),
    .dp    (cur_dp[idx]),
    .blank (lz_en && lz_mask[idx]),
    .segs  (dec_segs)
  );

  assign blank_phase = (cnt < CNT_BLANK);

  always_comb begin
    segs_next = SEG_BLANK;
    ctl_next  = CTL_OFF;
    if (!blank_phase) begin
      segs_next = dec_segs;
      ctl_next  = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      snap_dp    <= 4'h0;
      segs       <= SEG_BLANK;
      ssd_ctl    <= CTL_OFF;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) idx <= idx + 2'd1;
      end
      if (load) begin
        snap    <= digits_in;
        snap_dp <= dp_in;
      end
      segs       <= en ? segs_next : SEG_BLANK;
      ssd_ctl    <= en ? ctl_next : CTL_OFF;
      frame_done <= en && (idx == 2'd3) && wrap;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// k counts clock edges since reset release; outputs after edge k show slot k.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [7:0]  segs;
  logic [3:0]  ssd_ctl;
  logic        frame_done;

  int nassert = 0;
  int nfail = 0;
  int k = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .segs       (segs),
    .ssd_ctl    (ssd_ctl),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz;
    logic [7:0]  exp_segs [4];
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    nassert++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_segs", {8'h0, segs}, 16'h00FF);
    chk("reset_ctl", {12'h0, ssd_ctl}, 16'h000F);
    chk("reset_fd", {15'h0, frame_done}, 16'h0);
    reset = 1'b0;
    k = -1;
  endtask

  function automatic logic [3:0] on_ctl(input int i);
    logic [3:0] c;
    c = 4'hF;
    c[i] = 1'b0;
    return c;
  endfunction

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, '{8'h99, 8'h0D, 8'h25, 8'h9F}};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, '{8'h03, 8'h1F, 8'hFF, 8'hFF}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, '{8'h03, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3] = '{16'h00AF, 4'b0001, 1'b0, '{8'hFC, 8'hFD, 8'h03, 8'h03}};
    vecs[4] = '{16'h5678, 4'b1010, 1'b1, '{8'h01, 8'h1E, 8'h41, 8'h48}};
    vecs[5] = '{16'h0905, 4'b0100, 1'b1, '{8'h49, 8'h03, 8'h08, 8'hFF}};
    vecs[6] = '{16'h0009, 4'b1000, 1'b1, '{8'h09, 8'hFF, 8'hFF, 8'hFE}};
    vecs[7] = '{16'h0000, 4'b0000, 1'b0, '{8'h03, 8'h03, 8'h03, 8'h03}};

    reset = 1'b1;
    en = 1'b0;
    digits_in = 16'h0;
    dp_in = 4'h0;
    lz_en = 1'b0;
    @(negedge clk);

    // Table: one frame per vector, blank guard and drive phase per slot
    for (int v = 0; v < 8; v++) begin
      en = 1'b1;
      digits_in = vecs[v].digits;
      dp_in = vecs[v].dp;
      lz_en = vecs[v].lz;
      do_reset();
      for (int i = 0; i < 4; i++) begin
        go_to(8 * i + 1);
        chk($sformatf("v%0d_d%0d_guard_ctl", v, i),
            {12'h0, ssd_ctl}, 16'h000F);
        chk($sformatf("v%0d_d%0d_guard_segs", v, i),
            {8'h0, segs}, 16'h00FF);
        go_to(8 * i + 4);
        chk($sformatf("v%0d_d%0d_ctl", v, i),
            {12'h0, ssd_ctl}, {12'h0, on_ctl(i)});
        chk($sformatf("v%0d_d%0d_segs", v, i),
            {8'h0, segs}, {8'h0, vecs[v].exp_segs[i]});
      end
    end

    // Mid-frame input change and frame_done cadence
    digits_in = 16'h1234;
    dp_in = 4'h0;
    lz_en = 1'b0;
    do_reset();
    pulses = 0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (frame_done) pulses++;
      if (k == 0 || k == 1) chk("rel_blank", {8'h0, segs}, 16'h00FF);
      if (k == 2) chk("first_drive", {8'h0, segs}, 16'h0099);
      if (k == 18) digits_in = 16'h5678;
      if (k == 20) chk("hold_d2", {8'h0, segs}, 16'h0025);
      if (k == 28) chk("hold_d3", {8'h0, segs}, 16'h009F);
      if (k == 30) chk("fd_pre", {15'h0, frame_done}, 16'h0);
      if (k == 31) chk("fd_pulse", {15'h0, frame_done}, 16'h1);
      if (k == 32) chk("fd_post", {15'h0, frame_done}, 16'h0);
      if (k == 36) chk("new_d0", {8'h0, segs}, 16'h0001);
      if (k == 44) chk("new_d1", {8'h0, segs}, 16'h001F);
      if (k == 52) chk("new_d2", {8'h0, segs}, 16'h0041);
      if (k == 60) chk("new_d3", {8'h0, segs}, 16'h0049);
      if (k == 63) chk("fd_pulse2", {15'h0, frame_done}, 16'h1);
    end
    chk("fd_count", 16'(pulses), 16'd2);

    // en dropped after idx=1 cnt=5 for 10 cycles
    digits_in = 16'h1234;
    do_reset();
    go_to(13);
    chk("pre_hold_segs", {8'h0, segs}, 16'h000D);
    en = 1'b0;
    digits_in = 16'h9999;
    tick();
    chk("hold_segs", {8'h0, segs}, 16'h00FF);
    chk("hold_ctl", {12'h0, ssd_ctl}, 16'h000F);
    go_to(23);
    chk("hold_end_segs", {8'h0, segs}, 16'h00FF);
    chk("hold_fd", {15'h0, frame_done}, 16'h0);
    en = 1'b1;
    tick();
    chk("resume_ctl", {12'h0, ssd_ctl}, 16'h000D);
    chk("resume_segs", {8'h0, segs}, 16'h000D);
    tick();
    chk("resume_last", {8'h0, segs}, 16'h000D);
    tick();
    chk("resume_guard", {12'h0, ssd_ctl}, 16'h000F);
    go_to(28);
    chk("resume_d2", {8'h0, segs}, 16'h0025);
    go_to(40);
    chk("resume_fd_pre", {15'h0, frame_done}, 16'h0);
    tick();
    chk("resume_fd", {15'h0, frame_done}, 16'h1);

    // Reset pulsed mid-frame
    digits_in = 16'h1234;
    do_reset();
    go_to(20);
    chk("pre_rst_segs", {8'h0, segs}, 16'h0025);
    reset = 1'b1;
    digits_in = 16'h5678;
    tick();
    chk("rst_segs", {8'h0, segs}, 16'h00FF);
    chk("rst_ctl", {12'h0, ssd_ctl}, 16'h000F);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);
    reset = 1'b0;
    k = -1;
    go_to(4);
    chk("restart_ctl", {12'h0, ssd_ctl}, 16'h000E);
    chk("restart_segs", {8'h0, segs}, 16'h0001);

    // lz_en applies live to the held snapshot
    digits_in = 16'h0070;
    lz_en = 1'b0;
    do_reset();
    go_to(28);
    chk("lz_off_d3", {8'h0, segs}, 16'h0003);
    lz_en = 1'b1;
    tick();
    chk("lz_live_d3", {8'h0, segs}, 16'h00FF);
    chk("lz_live_ctl", {12'h0, ssd_ctl}, 16'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
